ppu_fetch_sequencer: RTL and testbench
======================================

PPU_FETCH_SEQUENCER -- requirements
Module: ppu_fetch_sequencer

Interface
REQ-001 SHALL have parameter DOT_DIV, default 4: clk cycles per PPU dot (>=1).
REQ-002 SHALL have parameter DOTS_PER_LINE, default 341: dots per scanline (dot 0..340).
REQ-003 SHALL have parameter LINES_PER_FRAME, default 262: lines per frame; prerender line = LINES_PER_FRAME-1.
REQ-004 SHALL have parameter VISIBLE_LINES, default 240: visible lines 0..239.
REQ-005 SHALL have parameter ODD_SKIP, default 1: 1 enables odd-frame dot skip.
REQ-006 Port: clk  input  1  system clock.
REQ-007 Port: rst  input  1  reset, synchronous, active-high.
REQ-008 Port: ppu_en  input  1  global run enable; 0 freezes all state.
REQ-009 Port: render_en  input  1  background or sprite rendering enabled.
REQ-010 Port: nmi_en  input  1  NMI generation enable.
REQ-011 Port: dot  output  9  current dot.
REQ-012 Port: line  output  9  current scanline.
REQ-013 Port: odd_frame  output  1  frame parity.
REQ-014 Port: fetch_type  output  3  IDLE=0, NT=1, AT=2, BG_LO=3, BG_HI=4, SP_NT=5, SP_LO=6, SP_HI=7.
REQ-015 Port: fetch_start  output  1  one-clk pulse at start of each 2-dot fetch.
REQ-016 Port: reload_shift, inc_hori, inc_vert, copy_hori, copy_vert  output  1 each  one-clk scroll/shifter strobes.
REQ-017 Port: vblank, nmi, frame_start  output  1 each  status/interrupt/frame-begin pulse.

Function
REQ-018 Prescaler SHALL count 0..DOT_DIV-1 while ppu_en=1; "dot tick" = prescaler==DOT_DIV-1; all strobes SHALL assert for exactly the clk where prescaler==0 of the named dot.
REQ-019 dot SHALL advance on dot tick, wrap DOTS_PER_LINE-1 -> 0 and advance line; line wraps prerender -> 0 and toggles odd_frame.
REQ-020 Odd skip: if ODD_SKIP && render_en && odd_frame && line==prerender && dot==DOTS_PER_LINE-2, next dot tick SHALL go to dot 0 line 0 (one dot shorter frame).
REQ-021 Rendering line = line<VISIBLE_LINES or line==prerender; fetches/strobes only on rendering lines with render_en=1, else fetch_type=IDLE, strobes 0.
REQ-022 BG fetch dots 1-256 and 321-336, per 8-dot group from dot d (d mod 8 ==1): NT d..d+1, AT d+2..d+3, BG_LO d+4..d+5, BG_HI d+6..d+7.
REQ-023 Sprite dots 257-320, per 8-dot group: SP_NT 4 dots, SP_LO 2, SP_HI 2.
REQ-024 Dots 337-340: NT, NT (two fetch_start pulses at 337, 339); dot 0: IDLE.
REQ-025 fetch_start SHALL pulse at each odd dot within fetch windows (first dot of a fetch pair).
REQ-026 reload_shift at dots 9,17,...,257 and 329,337; inc_hori at dots 8,16,...,256 and 328,336; inc_vert at dot 256; copy_hori at dot 257; copy_vert at dots 280-304 of prerender only.
REQ-027 vblank SHALL set at line VISIBLE_LINES+1 dot 1 and clear at prerender dot 1, independent of render_en.
REQ-028 nmi SHALL equal vblank && nmi_en (registered, one clk latency).
REQ-029 frame_start SHALL pulse at line 0 dot 0, including after odd skip.
REQ-030 render_en change mid-line SHALL take effect at next dot tick; no partial strobes.
REQ-031 ppu_en=0 SHALL hold counters, prescaler and outputs; strobes forced 0.

Reset
REQ-032 On rst: prescaler=0, dot=0, line=prerender, odd_frame=0, vblank=0, nmi=0, fetch_type=IDLE, all strobes 0; rst mid-frame overrides everything same clk.

Structure
REQ-033 fetch_type encodings and default timing constants SHALL live in shared package ppu_pkg.
REQ-034 One sub-module natural: ppu_dot_counter (prescaler + dot/line/odd counters); decode/FSM in top.

Verification
REQ-035 Reset, render_en=1, run: first fetch_start at line prerender dot 1 with fetch_type=NT, 5th clk after first dot-0 clk (DOT_DIV=4).
REQ-036 Line 0, dots 1-8 -> fetch_type NT,NT,AT,AT,BG_LO,BG_LO,BG_HI,BG_HI; reload_shift at dot 9; inc_hori at dot 8.
REQ-037 Odd frame, render_en=1 -> prerender line lasts 340 dots (1360 clk); render_en=0 -> 341 dots (1364 clk).
REQ-038 nmi_en=1 -> vblank and nmi rise at line 241 dot 1, fall at line 261 dot 1.
REQ-039 ppu_en=0 for 100 clk mid-line -> dot/line unchanged, no strobes; resume continues from same prescaler value.
REQ-040 rst asserted at line 120 dot 200 -> next clk dot=0, line=261, outputs at reset values.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU fetch sequencer.
//
// Contents:
//   fetch_type_t          - 3-bit encoding of the memory fetch in progress
//   DEF_*                 - default timing parameters (NTSC-style frame)
//   *_DOT constants       - fixed dot positions of fetch windows and strobes
//   bg_fetch / sp_fetch   - map the phase within an 8-dot group to a fetch type
package ppu_pkg;

    typedef enum logic [2:0] {
        FT_IDLE  = 3'd0,
        FT_NT    = 3'd1,
        FT_AT    = 3'd2,
        FT_BG_LO = 3'd3,
        FT_BG_HI = 3'd4,
        FT_SP_NT = 3'd5,
        FT_SP_LO = 3'd6,
        FT_SP_HI = 3'd7
    } fetch_type_t;

    localparam int DEF_DOT_DIV         = 4;
    localparam int DEF_DOTS_PER_LINE   = 341;
    localparam int DEF_LINES_PER_FRAME = 262;
    localparam int DEF_VISIBLE_LINES   = 240;
    localparam int DEF_ODD_SKIP        = 1;

    // Fetch windows within a scanline.
    localparam logic [8:0] BG_LAST_DOT     = 9'd256;  // background fetches 1..256
    localparam logic [8:0] SP_FIRST_DOT    = 9'd257;  // sprite fetches 257..320
    localparam logic [8:0] SP_LAST_DOT     = 9'd320;
    localparam logic [8:0] PF_FIRST_DOT    = 9'd321;  // next-line prefetch 321..336
    localparam logic [8:0] PF_LAST_DOT     = 9'd336;
    localparam logic [8:0] TAIL_FIRST_DOT  = 9'd337;  // dummy NT fetches 337..340
    localparam logic [8:0] TAIL_LAST_DOT   = 9'd340;

    // Scroll / shifter strobe positions.
    localparam logic [8:0] RELOAD_FIRST_DOT = 9'd9;
    localparam logic [8:0] RELOAD_LAST_DOT  = 9'd257;
    localparam logic [8:0] INC_H_FIRST_DOT  = 9'd8;
    localparam logic [8:0] INC_VERT_DOT     = 9'd256;
    localparam logic [8:0] COPY_HORI_DOT    = 9'd257;
    localparam logic [8:0] COPY_VERT_FIRST  = 9'd280;
    localparam logic [8:0] COPY_VERT_LAST   = 9'd304;
    localparam logic [8:0] PF_RELOAD_A_DOT  = 9'd329;
    localparam logic [8:0] PF_RELOAD_B_DOT  = 9'd337;
    localparam logic [8:0] PF_INC_A_DOT     = 9'd328;
    localparam logic [8:0] PF_INC_B_DOT     = 9'd336;

    // Background group: NT, NT, AT, AT, BG_LO, BG_LO, BG_HI, BG_HI.
    function automatic fetch_type_t bg_fetch(input logic [2:0] phase);
        case (phase[2:1])
            2'd0:    return FT_NT;
            2'd1:    return FT_AT;
            2'd2:    return FT_BG_LO;
            default: return FT_BG_HI;
        endcase
    endfunction

    // Sprite group: SP_NT x4, SP_LO x2, SP_HI x2.
    function automatic fetch_type_t sp_fetch(input logic [2:0] phase);
        if (!phase[2])
            return FT_SP_NT;
        else if (!phase[1])
            return FT_SP_LO;
        else
            return FT_SP_HI;
    endfunction

endpackage

// File: rtl/ppu_dot_counter.sv
// Prescaler plus dot / line / frame-parity counters for the PPU timing chain.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en           - run enable; 0 holds every register
//   render_en    - rendering enabled, used only for the odd-frame dot skip
//   pres_zero    - prescaler is at 0 (first clk of the current dot)
//   tick         - prescaler is at DOT_DIV-1 (dot advances on this clk edge)
//   dot, line    - current position
//   odd_frame    - frame parity, toggles whenever line wraps to 0
module ppu_dot_counter #(
    parameter int DOT_DIV         = 4,
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int ODD_SKIP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       render_en,
    output logic       pres_zero,
    output logic       tick,
    output logic [8:0] dot,
    output logic [8:0] line,
    output logic       odd_frame
);

    localparam int         PW        = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam logic [PW-1:0] PRES_LAST = PW'(DOT_DIV - 1);
    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LINE_PRE  = 9'(LINES_PER_FRAME - 1);

    logic [PW-1:0] pres;
    logic          skip;

    assign tick      = (pres == PRES_LAST);
    assign pres_zero = (pres == '0);

    // On odd frames with rendering on, the last dot of the prerender line is
    // dropped: the tick leaving dot DOTS_PER_LINE-2 goes straight to line 0.
    assign skip = (ODD_SKIP != 0) && render_en && odd_frame &&
                  (line == LINE_PRE) && (dot == DOT_SKIP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pres      <= '0;
            dot       <= 9'd0;
            line      <= LINE_PRE;
            odd_frame <= 1'b0;
        end else if (en) begin
            if (tick) begin
                pres <= '0;
                if (skip || (dot == DOT_LAST)) begin
                    dot <= 9'd0;
                    if (skip || (line == LINE_PRE)) begin
                        line      <= 9'd0;
                        odd_frame <= ~odd_frame;
                    end else begin
                        line <= line + 9'd1;
                    end
                end else begin
                    dot <= dot + 9'd1;
                end
            end else begin
                pres <= pres + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_fetch_sequencer.sv
// PPU scanline fetch sequencer: decodes the dot/line position into the
// memory fetch type, fetch-start pulses, scroll/shifter strobes, vblank/NMI
// status and the frame-begin pulse.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   ppu_en          - global run enable; 0 freezes all state, strobes forced 0
//   render_en       - rendering enabled (sampled at each dot boundary)
//   nmi_en          - NMI generation enable
//   dot, line       - current position
//   odd_frame       - frame parity
//   fetch_type      - fetch in progress (ppu_pkg::fetch_type_t encoding)
//   fetch_start     - one-clk pulse on the first clk of each 2-dot fetch
//   reload_shift, inc_hori, inc_vert, copy_hori, copy_vert
//                   - one-clk scroll/shifter strobes
//   vblank, nmi     - vertical blank status and registered interrupt
//   frame_start     - one-clk pulse on the first clk of line 0 dot 0
//
// All strobes fire on the clk where the prescaler is 0 within the named dot
// and ppu_en is 1, so each fires exactly once per dot even across pauses.
module ppu_fetch_sequencer
    import ppu_pkg::*;
#(
    parameter int DOT_DIV         = DEF_DOT_DIV,
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
    parameter int ODD_SKIP        = DEF_ODD_SKIP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ppu_en,
    input  logic       render_en,
    input  logic       nmi_en,
    output logic [8:0] dot,
    output logic [8:0] line,
    output logic       odd_frame,
    output logic [2:0] fetch_type,
    output logic       fetch_start,
    output logic       reload_shift,
    output logic       inc_hori,
    output logic       inc_vert,
    output logic       copy_hori,
    output logic       copy_vert,
    output logic       vblank,
    output logic       nmi,
    output logic       frame_start
);

    localparam logic [8:0] LINE_PRE = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] LINE_VIS = 9'(VISIBLE_LINES);
    localparam logic [8:0] LINE_VBL = 9'(VISIBLE_LINES + 1);

    logic        pres_zero;
    logic        tick;
    logic        render_q;     // render_en as seen at the start of this dot
    logic        render_line;
    logic        fetch_active;
    logic        strobe_en;
    logic [2:0]  phase;
    logic        in_bg;
    logic        in_sp;
    logic        in_tail;
    fetch_type_t ft;

    ppu_dot_counter #(
        .DOT_DIV         (DOT_DIV),
        .DOTS_PER_LINE   (DOTS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .ODD_SKIP        (ODD_SKIP)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (ppu_en),
        .render_en (render_en),
        .pres_zero (pres_zero),
        .tick      (tick),
        .dot       (dot),
        .line      (line),
        .odd_frame (odd_frame)
    );

    assign render_line  = (line < LINE_VIS) || (line == LINE_PRE);
    assign fetch_active = render_q && render_line;
    assign strobe_en    = fetch_active && ppu_en && pres_zero;

    // Groups start on dots with dot mod 8 == 1, so the low three bits minus
    // one give the position inside the group.
    assign phase   = dot[2:0] - 3'd1;
    assign in_bg   = ((dot != 9'd0) && (dot <= BG_LAST_DOT)) ||
                     ((dot >= PF_FIRST_DOT) && (dot <= PF_LAST_DOT));
    assign in_sp   = (dot >= SP_FIRST_DOT) && (dot <= SP_LAST_DOT);
    assign in_tail = (dot >= TAIL_FIRST_DOT) && (dot <= TAIL_LAST_DOT);

    always_comb begin
        ft = FT_IDLE;
        if (fetch_active) begin
            if (in_bg)
                ft = bg_fetch(phase);
            else if (in_sp)
                ft = sp_fetch(phase);
            else if (in_tail)
                ft = FT_NT;
        end
    end

    assign fetch_type = ft;

    // Every odd dot from 1 to 339 opens a 2-dot fetch.
    assign fetch_start  = strobe_en && dot[0] && (dot <= TAIL_LAST_DOT);

    assign reload_shift = strobe_en &&
                          (((dot[2:0] == 3'd1) && (dot >= RELOAD_FIRST_DOT) &&
                            (dot <= RELOAD_LAST_DOT)) ||
                           (dot == PF_RELOAD_A_DOT) || (dot == PF_RELOAD_B_DOT));

    assign inc_hori     = strobe_en &&
                          (((dot[2:0] == 3'd0) && (dot >= INC_H_FIRST_DOT) &&
                            (dot <= BG_LAST_DOT)) ||
                           (dot == PF_INC_A_DOT) || (dot == PF_INC_B_DOT));

    assign inc_vert     = strobe_en && (dot == INC_VERT_DOT);
    assign copy_hori    = strobe_en && (dot == COPY_HORI_DOT);
    assign copy_vert    = strobe_en && (line == LINE_PRE) &&
                          (dot >= COPY_VERT_FIRST) && (dot <= COPY_VERT_LAST);

    // Frame begin does not depend on rendering.
    assign frame_start  = ppu_en && pres_zero && (dot == 9'd0) && (line == 9'd0);

    // Dot 0 always advances to dot 1 (the odd skip leaves from a late dot),
    // so acting on the tick out of dot 0 makes vblank change on the first
    // clk of dot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            render_q <= 1'b0;
            vblank   <= 1'b0;
            nmi      <= 1'b0;
        end else if (ppu_en) begin
            nmi <= vblank && nmi_en;
            if (tick) begin
                render_q <= render_en;
                if ((dot == 9'd0) && (line == LINE_VBL))
                    vblank <= 1'b1;
                else if ((dot == 9'd0) && (line == LINE_PRE))
                    vblank <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_fetch_sequencer.sv
// Self-checking bench for ppu_fetch_sequencer. A short frame (6 lines) keeps
// runtime small while keeping full 341-dot lines and DOT_DIV=4. A position
// model tracks dot/line/parity and derives every output from the fetch
// tables; every clk is compared, plus directed checks on key events.
module tb_ppu_fetch_sequencer;

    localparam int DIV = 4;
    localparam int DPL = 341;
    localparam int LPF = 6;
    localparam int VIS = 3;
    localparam int PRE = LPF - 1;
    localparam int VBL = VIS + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ppu_en;
    logic       render_en;
    logic       nmi_en;
    logic [8:0] dot;
    logic [8:0] line;
    logic       odd_frame;
    logic [2:0] fetch_type;
    logic       fetch_start;
    logic       reload_shift;
    logic       inc_hori;
    logic       inc_vert;
    logic       copy_hori;
    logic       copy_vert;
    logic       vblank;
    logic       nmi;
    logic       frame_start;

    always #5 clk = ~clk;

    ppu_fetch_sequencer #(
        .DOT_DIV         (DIV),
        .DOTS_PER_LINE   (DPL),
        .LINES_PER_FRAME (LPF),
        .VISIBLE_LINES   (VIS),
        .ODD_SKIP        (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ppu_en       (ppu_en),
        .render_en    (render_en),
        .nmi_en       (nmi_en),
        .dot          (dot),
        .line         (line),
        .odd_frame    (odd_frame),
        .fetch_type   (fetch_type),
        .fetch_start  (fetch_start),
        .reload_shift (reload_shift),
        .inc_hori     (inc_hori),
        .inc_vert     (inc_vert),
        .copy_hori    (copy_hori),
        .copy_vert    (copy_vert),
        .vblank       (vblank),
        .nmi          (nmi),
        .frame_start  (frame_start)
    );

    int total = 0;
    int bad   = 0;

    // Reference position state.
    int   m_pres;
    int   m_dot;
    int   m_line;
    logic m_odd;
    logic m_vbl;
    logic m_nmi;
    logic m_ren;

    logic [2:0] bg_pat [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    logic [2:0] sp_pat [8] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    logic [2:0] line0_exp [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h (line=%0d dot=%0d)",
                     tag, obs, exp, m_line, m_dot);
            $error("comparison %s differs", tag);
        end
    endtask

    // Advance the reference by one clk edge using the inputs held at the edge.
    task automatic model_edge();
        if (rst) begin
            m_pres = 0; m_dot = 0; m_line = PRE;
            m_odd = 1'b0; m_vbl = 1'b0; m_nmi = 1'b0; m_ren = 1'b0;
        end else if (ppu_en) begin
            m_nmi = m_vbl && nmi_en;
            if (m_pres == DIV - 1) begin
                m_pres = 0;
                m_ren  = render_en;
                if (m_odd && render_en && m_line == PRE && m_dot == DPL - 2) begin
                    m_dot = 0; m_line = 0; m_odd = ~m_odd;
                end else if (m_dot == DPL - 1) begin
                    m_dot = 0;
                    if (m_line == PRE) begin
                        m_line = 0; m_odd = ~m_odd;
                    end else begin
                        m_line = m_line + 1;
                    end
                end else begin
                    m_dot = m_dot + 1;
                end
                if (m_dot == 1 && m_line == VBL) m_vbl = 1'b1;
                if (m_dot == 1 && m_line == PRE) m_vbl = 1'b0;
            end else begin
                m_pres = m_pres + 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic       act, sact, fs, rs, ih, iv, ch, cv, fr;
        logic [2:0] ft;
        int         d;
        d    = m_dot;
        act  = m_ren && ((m_line < VIS) || (m_line == PRE));
        sact = act && ppu_en && (m_pres == 0);
        ft   = 3'd0;
        if (act && d != 0) begin
            if (d <= 256 || (d >= 321 && d <= 336)) ft = bg_pat[(d - 1) % 8];
            else if (d <= 320)                      ft = sp_pat[(d - 1) % 8];
            else                                    ft = 3'd1;
        end
        fs = sact && (d % 2 == 1);
        rs = sact && ((d >= 9 && d <= 257 && d % 8 == 1) || d == 329 || d == 337);
        ih = sact && ((d >= 8 && d <= 256 && d % 8 == 0) || d == 328 || d == 336);
        iv = sact && (d == 256);
        ch = sact && (d == 257);
        cv = sact && (m_line == PRE) && (d >= 280 && d <= 304);
        fr = ppu_en && (m_pres == 0) && (d == 0) && (m_line == 0);
        return {1'b0, 9'(m_dot), 9'(m_line), m_odd, ft, fs, rs, ih, iv, ch, cv,
                m_vbl, m_nmi, fr};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {1'b0, dot, line, odd_frame, fetch_type, fetch_start, reload_shift,
                inc_hori, inc_vert, copy_hori, copy_vert, vblank, nmi, frame_start};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", dut_vec(), exp_vec());
    endtask

    task automatic run_until(input int l, input int d, input int p);
        int n;
        n = 0;
        while (!(m_line == l && m_dot == d && m_pres == p)) begin
            if (n >= 20000) begin
                total++;
                bad++;
                $display("FAIL run_until timeout target line=%0d dot=%0d", l, d);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic measure_prerender(input string tag, input int exp_clk);
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (frame_start !== 1'b1 && cnt < 2000);
        check(tag, cnt, exp_clk);
    endtask

    initial begin
        rst = 1'b1; ppu_en = 1'b1; render_en = 1'b1; nmi_en = 1'b1;
        m_pres = 0; m_dot = 0; m_line = PRE;
        m_odd = 1'b0; m_vbl = 1'b0; m_nmi = 1'b0; m_ren = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_dot", dot, 0);
        check("rst_line", line, PRE);
        check("rst_odd", odd_frame, 0);
        check("rst_vblank", vblank, 0);
        check("rst_nmi", nmi, 0);
        check("rst_ftype", fetch_type, 0);

        // First fetch: 5th clk counting the first dot-0 clk after reset.
        rst = 1'b0;
        repeat (3) step();
        check("first_fs_early", fetch_start, 0);
        step();
        check("first_fs", fetch_start, 1);
        check("first_ftype", fetch_type, 1);
        check("first_dot", dot, 1);
        check("first_line", line, PRE);

        // Line 0 start and first background group.
        run_until(0, 0, 0);
        check("frame_start", frame_start, 1);
        check("odd_after_wrap", odd_frame, 1);
        for (int d = 1; d <= 8; d++) begin
            run_until(0, d, 0);
            check($sformatf("l0_ftype_d%0d", d), fetch_type, line0_exp[d - 1]);
            if (d == 8) check("inc_hori_d8", inc_hori, 1);
        end
        run_until(0, 9, 0);
        check("reload_d9", reload_shift, 1);
        run_until(0, 256, 0);
        check("inc_vert_d256", inc_vert, 1);
        run_until(0, 257, 0);
        check("copy_hori_d257", copy_hori, 1);
        check("sp_ftype_d257", fetch_type, 5);

        // Pause mid-line: position frozen, prescaler resumes where it was.
        run_until(1, 100, 2);
        ppu_en = 1'b0;
        repeat (100) step();
        check("pause_dot", dot, 100);
        check("pause_line", line, 1);
        ppu_en = 1'b1;
        step();
        check("resume_dot_hold", dot, 100);
        step();
        check("resume_dot_adv", dot, 101);

        // Vblank / NMI rise.
        run_until(VBL, 0, 3);
        check("vbl_before", vblank, 0);
        step();
        check("vbl_rise", vblank, 1);
        check("vbl_rise_dot", dot, 1);
        step();
        check("nmi_rise", nmi, 1);

        // Odd-frame prerender with rendering: one dot shorter.
        run_until(PRE, 0, 0);
        measure_prerender("odd_pre_len_render", 1360);
        check("odd_after_skip", odd_frame, 0);
        check("skip_line", line, 0);

        // Even frame: vblank/NMI fall and copy_vert window.
        run_until(PRE, 0, 3);
        check("vbl_hold", vblank, 1);
        step();
        check("vbl_fall", vblank, 0);
        step();
        check("nmi_fall", nmi, 0);
        run_until(PRE, 279, 0);
        check("copy_vert_279", copy_vert, 0);
        run_until(PRE, 280, 0);
        check("copy_vert_280", copy_vert, 1);
        run_until(PRE, 304, 0);
        check("copy_vert_304", copy_vert, 1);
        run_until(PRE, 305, 0);
        check("copy_vert_305", copy_vert, 0);

        // Odd-frame prerender with rendering off: full length.
        run_until(PRE, 0, 0);
        check("odd_pre_parity", odd_frame, 1);
        render_en = 1'b0;
        measure_prerender("odd_pre_len_norender", 1364);
        render_en = 1'b1;

        // Randomised enables, checked every clk against the model.
        for (int i = 0; i < 16000; i++) begin
            ppu_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) render_en = ~render_en;
            if ($urandom_range(0, 299) == 0) nmi_en = ~nmi_en;
            step();
        end

        // Reset mid-frame.
        ppu_en = 1'b1; render_en = 1'b1;
        run_until(2, 200, 0);
        rst = 1'b1;
        step();
        check("midrst_dot", dot, 0);
        check("midrst_line", line, PRE);
        check("midrst_odd", odd_frame, 0);
        check("midrst_vblank", vblank, 0);
        check("midrst_nmi", nmi, 0);
        check("midrst_ftype", fetch_type, 0);
        check("midrst_fs", fetch_start, 0);
        rst = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
